// File: rtl/mmio_pkg.sv
// mmio_io_hub shared definitions: default address map and register index helpers.
package mmio_pkg;

    localparam logic [31:0] DEF_BASE_AD = 32'h1100_0000;
    localparam logic [31:0] DEF_STRIDE  = 32'h0004_0000;

    // IRQ register indices relative to NUM_IN+NUM_OUT
    localparam int IRQ_STATUS_OFS = 0;
    localparam int IRQ_MASK_OFS   = 1;

    function automatic logic [31:0] reg_addr(
        input int          k,
        input logic [31:0] base   = DEF_BASE_AD,
        input logic [31:0] stride = DEF_STRIDE
    );
        return base + 32'(k) * stride;
    endfunction

endpackage

// File: rtl/mmio_io_hub_in_sync_edge.sv
// Per-channel two-flop input synchroniser with a history flop for rising-edge
// detection on any bit of the channel.
module in_sync_edge #(
    parameter int IN_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] din,
    output logic [IN_W-1:0] sync,
    output logic            rise
);

    logic [IN_W-1:0] sync1;
    logic [IN_W-1:0] sync2;
    logic [IN_W-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign sync = sync2;
    assign rise = |(sync2 & ~prev);

endmodule

// File: rtl/mmio_io_hub.sv
// OTTER IOBUS hub: synchronised inputs, output registers, edge interrupts.
// Optional MMIO_WSTROBE_EN adds OUT_WSTB write-strobe outputs.
module mmio_io_hub
    import mmio_pkg::*;
#(
    parameter int          NUM_IN  = 4,
    parameter int          IN_W    = 16,
    parameter int          NUM_OUT = 4,
    parameter logic [31:0] BASE_AD = DEF_BASE_AD,
    parameter logic [31:0] STRIDE  = DEF_STRIDE,
    parameter logic [31:0] OUT_RST = 32'h0
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [31:0]             IOBUS_ADDR,
    input  logic [31:0]             IOBUS_OUT,
    input  logic                    IOBUS_WR,
    output logic [31:0]             IOBUS_IN,
    input  logic [NUM_IN*IN_W-1:0]  IN_DATA,
    output logic [NUM_OUT*32-1:0]   OUT_DATA,
    output logic                    INTR
`ifdef MMIO_WSTROBE_EN
    ,
    output logic [NUM_OUT-1:0]      OUT_WSTB
`endif
);

    localparam int STAT_IDX = NUM_IN + NUM_OUT + IRQ_STATUS_OFS;
    localparam int MASK_IDX = NUM_IN + NUM_OUT + IRQ_MASK_OFS;

    logic [IN_W-1:0]    in_val [NUM_IN];
    logic [NUM_IN-1:0]  rise;
    logic [NUM_IN-1:0]  pending;
    logic [NUM_IN-1:0]  mask;
    logic [NUM_IN-1:0]  clr;
    logic [31:0]        out_reg [NUM_OUT];
    logic [NUM_OUT-1:0] out_hit;
    logic               stat_hit;
    logic               mask_hit;
    logic [31:0]        rd_data;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        in_sync_edge #(.IN_W(IN_W)) u_sync (
            .clk   (CLK),
            .rst_n (RST_N),
            .din   (IN_DATA[i*IN_W +: IN_W]),
            .sync  (in_val[i]),
            .rise  (rise[i])
        );
    end

    always_comb begin
        out_hit = '0;
        for (int j = 0; j < NUM_OUT; j++)
            out_hit[j] = IOBUS_WR &&
                (IOBUS_ADDR == reg_addr(NUM_IN + j, BASE_AD, STRIDE));
        stat_hit = IOBUS_WR &&
            (IOBUS_ADDR == reg_addr(STAT_IDX, BASE_AD, STRIDE));
        mask_hit = IOBUS_WR &&
            (IOBUS_ADDR == reg_addr(MASK_IDX, BASE_AD, STRIDE));
    end

    assign clr = stat_hit ? IOBUS_OUT[NUM_IN-1:0] : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int j = 0; j < NUM_OUT; j++) out_reg[j] <= OUT_RST;
        end else begin
            for (int j = 0; j < NUM_OUT; j++)
                if (out_hit[j]) out_reg[j] <= IOBUS_OUT;
        end
    end

    // a new edge outranks a same-cycle W1C of the same bit
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
            if (mask_hit) mask <= IOBUS_OUT[NUM_IN-1:0];
        end
    end

`ifdef MMIO_WSTROBE_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) OUT_WSTB <= '0;
        else        OUT_WSTB <= out_hit;
    end
`endif

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_IN; k++)
            if (IOBUS_ADDR == reg_addr(k, BASE_AD, STRIDE))
                rd_data[IN_W-1:0] = in_val[k];
        for (int j = 0; j < NUM_OUT; j++)
            if (IOBUS_ADDR == reg_addr(NUM_IN + j, BASE_AD, STRIDE))
                rd_data = out_reg[j];
        if (IOBUS_ADDR == reg_addr(STAT_IDX, BASE_AD, STRIDE))
            rd_data[NUM_IN-1:0] = pending;
        if (IOBUS_ADDR == reg_addr(MASK_IDX, BASE_AD, STRIDE))
            rd_data[NUM_IN-1:0] = mask;
    end

    assign IOBUS_IN = rd_data;
    assign INTR     = |(pending & mask);

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        assign OUT_DATA[j*32 +: 32] = out_reg[j];
    end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed + random bench for mmio_io_hub against a sample-history model.
// Build with MMIO_WSTROBE_EN to also check the OUT_WSTB strobes.
module tb_mmio_io_hub;

    localparam int          NUM_IN  = 4;
    localparam int          IN_W    = 16;
    localparam int          NUM_OUT = 4;
    localparam logic [31:0] OUT_RST = 32'hA5;

    logic                   CLK = 1'b0;
    logic                   RST_N = 1'b0;
    logic [31:0]            addr = '0;
    logic [31:0]            wdata = '0;
    logic                   wr = 1'b0;
    logic [31:0]            rdata;
    logic [NUM_IN*IN_W-1:0] IN_DATA = '0;
    logic [NUM_OUT*32-1:0]  OUT_DATA;
    logic                   INTR;
`ifdef MMIO_WSTROBE_EN
    logic [NUM_OUT-1:0]     OUT_WSTB;
`endif

    mmio_io_hub #(
        .NUM_IN(NUM_IN), .IN_W(IN_W), .NUM_OUT(NUM_OUT),
        .BASE_AD(32'h1100_0000), .STRIDE(32'h0004_0000),
        .OUT_RST(OUT_RST)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IOBUS_ADDR(addr), .IOBUS_OUT(wdata), .IOBUS_WR(wr),
        .IOBUS_IN(rdata), .IN_DATA(IN_DATA), .OUT_DATA(OUT_DATA),
        .INTR(INTR)
`ifdef MMIO_WSTROBE_EN
        , .OUT_WSTB(OUT_WSTB)
`endif
    );

    always #10 CLK = ~CLK;

    // h0 = input sampled at the latest edge, h1 one edge earlier, h2 two
    logic [NUM_IN*IN_W-1:0] h0, h1, h2;
    logic [31:0]            m_out [NUM_OUT];
    logic [NUM_IN-1:0]      m_pend, m_mask;
    logic [NUM_OUT-1:0]     m_wstb;
    int total = 0;
    int bad = 0;

    function automatic logic [31:0] ad(input int k);
        return 32'h1100_0000 + 32'(k) * 32'h0004_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        h0 = '0; h1 = '0; h2 = '0;
        for (int j = 0; j < NUM_OUT; j++) m_out[j] = OUT_RST;
        m_pend = '0; m_mask = '0; m_wstb = '0;
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < NUM_IN; k++)
            if (a == ad(k)) r = 32'(h1[k*IN_W +: IN_W]);
        for (int j = 0; j < NUM_OUT; j++)
            if (a == ad(NUM_IN + j)) r = m_out[j];
        if (a == ad(NUM_IN + NUM_OUT)) r = 32'(m_pend);
        if (a == ad(NUM_IN + NUM_OUT + 1)) r = 32'(m_mask);
        return r;
    endfunction

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        wr = 1'b0;
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic tick();
        logic [NUM_IN-1:0]      rise, clr, npend, nmask;
        logic [NUM_OUT-1:0]     nwstb;
        logic [31:0]            nout [NUM_OUT];
        logic [NUM_IN*IN_W-1:0] smp;
        for (int c = 0; c < NUM_IN; c++)
            rise[c] = |(h1[c*IN_W +: IN_W] & ~h2[c*IN_W +: IN_W]);
        clr = (wr && addr == ad(NUM_IN + NUM_OUT)) ? wdata[NUM_IN-1:0] : '0;
        npend = (m_pend & ~clr) | rise;
        nmask = (wr && addr == ad(NUM_IN + NUM_OUT + 1)) ?
                wdata[NUM_IN-1:0] : m_mask;
        for (int j = 0; j < NUM_OUT; j++) begin
            nwstb[j] = wr && addr == ad(NUM_IN + j);
            nout[j] = nwstb[j] ? wdata : m_out[j];
        end
        smp = IN_DATA;
        @(posedge CLK);
        h2 = h1; h1 = h0; h0 = smp;
        m_pend = npend; m_mask = nmask; m_wstb = nwstb;
        for (int j = 0; j < NUM_OUT; j++) m_out[j] = nout[j];
        #1;
    endtask

    task automatic check_all(input string ph);
        logic [31:0] v;
        chk({ph, ":intr"}, 32'(INTR), 32'(|(m_pend & m_mask)));
        for (int j = 0; j < NUM_OUT; j++)
            chk($sformatf("%s:out%0d", ph, j), OUT_DATA[j*32 +: 32], m_out[j]);
`ifdef MMIO_WSTROBE_EN
        chk({ph, ":wstb"}, 32'(OUT_WSTB), 32'(m_wstb));
`endif
        for (int k = 0; k < NUM_IN + NUM_OUT + 2; k++)
            if (k < NUM_IN || k >= NUM_IN + NUM_OUT) begin
                rd(ad(k), v);
                chk($sformatf("%s:rd%0d", ph, k), v, exp_read(ad(k)));
            end
    endtask

    task automatic op(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input string ph);
        wr = w; addr = a; wdata = d;
        tick();
        wr = 1'b0;
        check_all(ph);
    endtask

    initial begin
        logic [31:0] v;
        model_reset();
        #25;
        rd(ad(4), v);
        chk("rst_out0_rd", v, 32'hA5);
        chk("rst_intr", 32'(INTR), 32'h0);
        rd(ad(8), v);
        chk("rst_status", v, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        op(1'b0, '0, '0, "post_rst");

        op(1'b1, 32'h1110_0000, 32'h1234, "wr_out0");
        chk("out0_port", OUT_DATA[31:0], 32'h1234);
        rd(32'h1110_0000, v);
        chk("out0_rd", v, 32'h0000_1234);

        IN_DATA[31:16] = 16'h00F0;
        op(1'b0, '0, '0, "in1_e1");
        rd(32'h1104_0000, v);
        chk("in1_after1", v, 32'h0);
        op(1'b0, '0, '0, "in1_e2");
        rd(32'h1104_0000, v);
        chk("in1_after2", v, 32'h0000_00F0);
        op(1'b0, '0, '0, "in1_e3");
        rd(32'h1120_0000, v);
        chk("stat_after3", v, 32'h2);
        chk("intr_masked", 32'(INTR), 32'h0);

        op(1'b1, 32'h1124_0000, 32'h2, "mask_wr");
        chk("intr_unmask", 32'(INTR), 32'h1);
        op(1'b1, 32'h1120_0000, 32'h2, "w1c");
        rd(32'h1120_0000, v);
        chk("stat_w1c", v, 32'h0);
        chk("intr_w1c", 32'(INTR), 32'h0);

        IN_DATA[31:16] = 16'h0000;
        repeat (3) op(1'b0, '0, '0, "fall");
        IN_DATA[31:16] = 16'h00F0;
        op(1'b0, '0, '0, "race_e1");
        op(1'b0, '0, '0, "race_e2");
        op(1'b1, 32'h1120_0000, 32'h2, "race_e3");
        rd(32'h1120_0000, v);
        chk("race_set_wins", v, 32'h2);
        op(1'b1, 32'h1120_0000, 32'h2, "race_clr");
        rd(32'h1120_0000, v);
        chk("race_clr", v, 32'h0);

        op(1'b1, 32'h1100_0000, 32'hFFFF, "wr_in0");
        op(1'b1, 32'h1130_0000, 32'hFFFF, "wr_unmapped");
        rd(32'h1130_0000, v);
        chk("unmapped_rd", v, 32'h0);

        op(1'b1, 32'h1118_0000, 32'hDEAD, "out2_dead");
        op(1'b1, 32'h1124_0000, 32'hF, "mask_f");
        IN_DATA = 64'h1;
        RST_N = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_out2", OUT_DATA[95:64], 32'hA5);
        rd(32'h1124_0000, v);
        chk("mid_rst_mask", v, 32'h0);
        chk("mid_rst_intr", 32'(INTR), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        op(1'b0, '0, '0, "rel_e1");
        op(1'b0, '0, '0, "rel_e2");
        rd(32'h1120_0000, v);
        chk("rel_stat2", v, 32'h0);
        op(1'b0, '0, '0, "rel_e3");
        rd(32'h1120_0000, v);
        chk("rel_stat3", v, 32'h1);

        op(1'b1, 32'h111C_0000, 32'h1, "wstb_a");
`ifdef MMIO_WSTROBE_EN
        chk("wstb3_c1", 32'(OUT_WSTB[3]), 32'h1);
`endif
        op(1'b1, 32'h111C_0000, 32'h1, "wstb_b");
`ifdef MMIO_WSTROBE_EN
        chk("wstb3_c2", 32'(OUT_WSTB[3]), 32'h1);
`endif
        op(1'b0, '0, '0, "wstb_idle");
`ifdef MMIO_WSTROBE_EN
        chk("wstb3_off", 32'(OUT_WSTB[3]), 32'h0);
`endif

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0)
                IN_DATA = {$urandom, $urandom} & {$urandom, $urandom};
            a = ($urandom_range(0, 15) == 0) ? $urandom :
                ad($urandom_range(0, NUM_IN + NUM_OUT + 3));
            op(1'($urandom_range(0, 1)), a, $urandom, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 79) == 0) begin
                RST_N = 1'b0;
                model_reset();
                #1;
                check_all($sformatf("rnd_rst%0d", n));
                @(negedge CLK);
                RST_N = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
